// File: rtl/uart_tx_cfg_pkg.sv
`default_nettype none
// ============================================================================
// Module  : uart_pkg
// Brief   : Shared FSM encodings, legal-range checks and divisor clamp.
// Revision: 1.0 - initial release
// ============================================================================
package uart_pkg;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP   = 3'd4;

  localparam int DATA_BITS_MIN  = 5;
  localparam int DATA_BITS_MAX  = 9;
  localparam int FIFO_DEPTH_MIN = 2;
  localparam int FIFO_DEPTH_MAX = 64;

  // Divisors below this are clamped up so every bit spans at least two clocks.
  localparam int DIV_MIN = 2;

  function automatic bit data_bits_ok(input int n);
    return (n >= DATA_BITS_MIN) && (n <= DATA_BITS_MAX);
  endfunction

  function automatic bit fifo_depth_ok(input int n);
    return (n >= FIFO_DEPTH_MIN) && (n <= FIFO_DEPTH_MAX) && ((n & (n - 1)) == 0);
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_cfg_if.sv
`default_nettype none
// ============================================================================
// Module  : uart_tx_cfg_if
// Brief   : Producer-side STB/ACK byte write channel of the UART transmitter.
// Revision: 1.0 - initial release
// ============================================================================
interface uart_tx_cfg_if #(
  parameter int DATA_BITS = 8
) ();

  logic                 STBi;
  logic [DATA_BITS-1:0] DATi;
  logic                 ACKi;

  modport master (
    output STBi,
    output DATi,
    input  ACKi
  );

  modport slave (
    input  STBi,
    input  DATi,
    output ACKi
  );

endinterface
`default_nettype wire

// File: rtl/uart_tx_cfg_fifo.sv
`default_nettype none
// ============================================================================
// Module  : uart_tx_fifo
// Brief   : Synchronous first-word-fall-through FIFO with wrap-flag pointers.
// Revision: 1.0 - initial release
// ============================================================================
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 CLK,
  input  logic                 RSTn,
  input  logic                 WR,
  input  logic [DATA_BITS-1:0] WDAT,
  input  logic                 RD,
  output logic [DATA_BITS-1:0] RDAT,
  output logic                 FULL,
  output logic                 EMPTY
);

  localparam int            c_AW      = $clog2(FIFO_DEPTH);
  localparam logic [c_AW:0] c_PTR_ONE = (c_AW + 1)'(1);

  if (!fifo_depth_ok(FIFO_DEPTH)) begin : g_bad_fifo_depth
    $error("uart_tx_fifo: FIFO_DEPTH must be a power of two in 2..64");
  end

  logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
  logic [c_AW:0]        r_wptr;
  logic [c_AW:0]        r_rptr;
  logic                 w_rd;
  logic                 w_wr;

  assign EMPTY = (r_wptr == r_rptr);
  assign FULL  = (r_wptr[c_AW] != r_rptr[c_AW]) &&
                 (r_wptr[c_AW-1:0] == r_rptr[c_AW-1:0]);

  // A pop in the same cycle frees a slot, so a full FIFO still takes the write.
  assign w_rd = RD && !EMPTY;
  assign w_wr = WR && (!FULL || w_rd);

  assign RDAT = r_mem[r_rptr[c_AW-1:0]];

  always_ff @(posedge CLK) begin
    if (w_wr) begin
      r_mem[r_wptr[c_AW-1:0]] <= WDAT;
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_wr) begin
        r_wptr <= r_wptr + c_PTR_ONE;
      end
      if (w_rd) begin
        r_rptr <= r_rptr + c_PTR_ONE;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_tx_cfg.sv
`default_nettype none
// ============================================================================
// Module  : uart_tx_cfg
// Brief   : Configurable UART transmitter with TX FIFO and frame-aligned baud.
// Revision: 1.0 - initial release
// ============================================================================
module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int DIV_W      = 16
) (
  input  logic             CLK,
  input  logic             RSTn,
  uart_tx_cfg_if.slave     bus,
  input  logic [DIV_W-1:0] DIV,
  input  logic             PAR_EN,
  input  logic             PAR_ODD,
  input  logic             STOP2,
  output logic             TXD,
  output logic             BUSY,
  output logic             FIFO_EMPTY
);

  localparam int               c_BCW      = $clog2(DATA_BITS + 1);
  localparam logic [DIV_W-1:0] c_DIV_ONE  = DIV_W'(1);
  localparam logic [DIV_W-1:0] c_DIV_MIN  = DIV_W'(DIV_MIN);
  localparam logic [c_BCW-1:0] c_BC_ONE   = c_BCW'(1);
  localparam logic [c_BCW-1:0] c_LAST_BIT = c_BCW'(DATA_BITS - 1);

  if (!data_bits_ok(DATA_BITS)) begin : g_bad_data_bits
    $error("uart_tx_cfg: DATA_BITS must be in 5..9");
  end

  logic [2:0]           r_state;
  logic [DIV_W-1:0]     r_cnt;
  logic [DIV_W-1:0]     r_div;
  logic [DATA_BITS-1:0] r_shift;
  logic [c_BCW-1:0]     r_bitcnt;
  logic                 r_par_en;
  logic                 r_par_bit;
  logic                 r_stop2;
  logic                 r_txd;
  logic                 r_ack;

  logic                 w_full;
  logic                 w_empty;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_bit_end;
  logic                 w_frame_end;
  logic [DATA_BITS-1:0] w_rdat;
  logic [DIV_W-1:0]     w_div_eff;

  assign w_div_eff   = (DIV < c_DIV_MIN) ? c_DIV_MIN : DIV;
  assign w_bit_end   = (r_cnt == '0);
  assign w_frame_end = (r_state == STOP) && w_bit_end && (r_bitcnt == '0);

  // Popping at the last STOP cycle chains the next START with no idle gap.
  assign w_pop  = !w_empty && ((r_state == IDLE) || w_frame_end);
  assign w_push = bus.STBi && !r_ack && (!w_full || w_pop);

  uart_tx_fifo #(
    .DATA_BITS  (DATA_BITS),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .CLK   (CLK),
    .RSTn  (RSTn),
    .WR    (w_push),
    .WDAT  (bus.DATi),
    .RD    (w_pop),
    .RDAT  (w_rdat),
    .FULL  (w_full),
    .EMPTY (w_empty)
  );

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_ack <= 1'b0;
    end else begin
      r_ack <= w_push;
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_div     <= c_DIV_MIN;
      r_shift   <= '0;
      r_bitcnt  <= '0;
      r_par_en  <= 1'b0;
      r_par_bit <= 1'b0;
      r_stop2   <= 1'b0;
      r_txd     <= 1'b1;
    end else begin
      if (r_state != IDLE) begin
        if (w_bit_end) begin
          r_cnt <= r_div - c_DIV_ONE;
          case (r_state)
            START: begin
              r_state  <= DATA;
              r_txd    <= r_shift[0];
              r_shift  <= r_shift >> 1;
              r_bitcnt <= '0;
            end
            DATA: begin
              if (r_bitcnt == c_LAST_BIT) begin
                // Reused as the remaining-stop-bits counter from here on.
                r_bitcnt <= {{(c_BCW-1){1'b0}}, r_stop2};
                if (r_par_en) begin
                  r_state <= PARITY;
                  r_txd   <= r_par_bit;
                end else begin
                  r_state <= STOP;
                  r_txd   <= 1'b1;
                end
              end else begin
                r_bitcnt <= r_bitcnt + c_BC_ONE;
                r_txd    <= r_shift[0];
                r_shift  <= r_shift >> 1;
              end
            end
            PARITY: begin
              r_state <= STOP;
              r_txd   <= 1'b1;
            end
            STOP: begin
              if (r_bitcnt != '0) begin
                r_bitcnt <= r_bitcnt - c_BC_ONE;
              end else begin
                r_state <= IDLE;
                r_txd   <= 1'b1;
              end
            end
            default: begin
              r_state <= IDLE;
              r_txd   <= 1'b1;
            end
          endcase
        end else begin
          r_cnt <= r_cnt - c_DIV_ONE;
        end
      end

      // Frame load wins over the STOP->IDLE step above; config is frozen here.
      if (w_pop) begin
        r_state   <= START;
        r_txd     <= 1'b0;
        r_shift   <= w_rdat;
        r_div     <= w_div_eff;
        r_cnt     <= w_div_eff - c_DIV_ONE;
        r_par_en  <= PAR_EN;
        r_par_bit <= (^w_rdat) ^ PAR_ODD;
        r_stop2   <= STOP2;
      end
    end
  end

  assign TXD        = r_txd;
  assign BUSY       = (r_state != IDLE);
  assign FIFO_EMPTY = w_empty;
  assign bus.ACKi   = r_ack;

endmodule
`default_nettype wire
